// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and constants for the DSP48A1 dot-product sequencer.
package dsp_seq_pkg;

  // OPMODE words for the slice: X mux in [1:0], Z mux in [3:2]
  localparam logic [7:0] OPM_FIRST = 8'h01;  // P = M
  localparam logic [7:0] OPM_ACC   = 8'h09;  // P = P + M
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // P = P

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    OUT
  } state_t;

  // Per-beat tag travelling alongside the operands through the slice
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  // Map a tag to the OPMODE word that must meet its product at the post-adder
  function automatic logic [7:0] opmodeFor(tag_t t);
    logic [2:0] bits;
    logic [7:0] op;
    bits = t;
    case (bits) inside
      3'b0??:  op = OPM_HOLD;
      3'b11?:  op = OPM_FIRST;
      default: op = OPM_ACC;
    endcase
    return op;
  endfunction

  // True when the tag marks the final product of a frame
  function automatic logic isFinal(tag_t t);
    logic [2:0] bits;
    bits = t;
    return (bits ==? 3'b1?1);
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand and result valid/ready streams of the dot-product sequencer.
interface dsp_mac_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic        m_valid;
  logic        m_ready;
  logic [47:0] m_data;

  // The sequencer sinks operands and sources results
  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_data
  );

  // The environment sources operands and sinks results
  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// Fixed-depth shift register that delays beat tags to line up with the slice.
module dsp_tag_pipe
  import dsp_seq_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [DEPTH];

  // Shift the tag one stage per clock; reset flushes everything to bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Feeds operand pairs into a DSP48A1 slice and collects N_TAPS-long dot products
// from its P accumulator. Every beat carries a tag so OPMODE and the result
// capture line up with the slice's internal register stages.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int N_TAPS     = 8,
  parameter int OPMODE_DLY = 1,
  parameter int P_LAT      = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  dsp_mac_sequencer_if.slave        bus,
  output logic [17:0]               dsp_a,
  output logic [17:0]               dsp_b,
  output logic [7:0]                dsp_opmode,
  output logic                      dsp_ce,
  input  logic [47:0]               dsp_p,
  output logic                      busy
);

  localparam int TW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [TW-1:0] LAST_IDX = TW'(N_TAPS - 1);

  state_t        state_q;
  logic [TW-1:0] tapCnt_q;
  logic [17:0]   dspA_q;
  logic [17:0]   dspB_q;
  logic [7:0]    dspOpmode_q;
  logic          dspCe_q;
  logic          sReady_q;
  logic          mValid_q;
  logic [47:0]   mData_q;

  // tag_d is the tag issued this cycle, tag_q sits alongside dsp_a/dsp_b
  tag_t tag_d;
  tag_t tag_q;
  tag_t opmTag;
  tag_t resTag;
  logic accept;

  assign accept = bus.s_valid && sReady_q;

  // Build the tag for this cycle: a real beat or a bubble
  always_comb begin
    tag_d = '0;
    if (accept) begin
      tag_d.valid = 1'b1;
      tag_d.first = (tapCnt_q == '0);
      tag_d.last  = (tapCnt_q == LAST_IDX);
    end
  end

  // The opmode pipe ends one stage early because dsp_opmode is itself registered
  dsp_tag_pipe #(.DEPTH(OPMODE_DLY)) u_opm_pipe (
    .clk   (CLK),
    .rst   (RST),
    .tag_i (tag_d),
    .tag_o (opmTag)
  );

  // Fed from tag_q so its output lines up with the beat's contribution on dsp_p
  dsp_tag_pipe #(.DEPTH(P_LAT)) u_res_pipe (
    .clk   (CLK),
    .rst   (RST),
    .tag_i (tag_q),
    .tag_o (resTag)
  );

  // Sequencer FSM with the registered slice drive and result outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ACCUM;
      tapCnt_q    <= '0;
      dspA_q      <= '0;
      dspB_q      <= '0;
      dspOpmode_q <= 8'h00;
      dspCe_q     <= 1'b0;
      sReady_q    <= 1'b0;
      mValid_q    <= 1'b0;
      mData_q     <= '0;
      tag_q       <= '0;
    end else begin
      dspCe_q     <= 1'b1;
      dspA_q      <= accept ? bus.s_a : 18'd0;
      dspB_q      <= accept ? bus.s_b : 18'd0;
      tag_q       <= tag_d;
      dspOpmode_q <= opmodeFor(opmTag);
      case (state_q)
        ACCUM: begin
          sReady_q <= 1'b1;
          if (accept) begin
            if (tapCnt_q == LAST_IDX) begin
              tapCnt_q <= '0;
              sReady_q <= 1'b0;
              state_q  <= DRAIN;
            end else begin
              tapCnt_q <= tapCnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (isFinal(resTag)) begin
            mData_q  <= dsp_p;
            mValid_q <= 1'b1;
            state_q  <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            mValid_q <= 1'b0;
            sReady_q <= 1'b1;
            state_q  <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign dsp_a       = dspA_q;
  assign dsp_b       = dspB_q;
  assign dsp_opmode  = dspOpmode_q;
  assign dsp_ce      = dspCe_q;
  assign bus.s_ready = sReady_q;
  assign bus.m_valid = mValid_q;
  assign bus.m_data  = mData_q;
  assign busy        = (state_q != ACCUM) || (tapCnt_q != '0);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: two instances (4 taps and 1 tap), each driving a
// behavioural DSP48A1 slice, with a scoreboard of expected dot products.
module tb_dsp_mac_sequencer;

  localparam int LAT = 4;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  dsp_mac_sequencer_if bus4();
  dsp_mac_sequencer_if bus1();

  logic [17:0] dspA4, dspB4, dspA1, dspB1;
  logic [7:0]  opm4, opm1;
  logic        ce4, ce1, busy4, busy1;
  logic [47:0] p4, p1;

  dsp_mac_sequencer #(.N_TAPS(4), .OPMODE_DLY(1), .P_LAT(3)) dut4 (
    .CLK(CLK), .RST(RST), .bus(bus4),
    .dsp_a(dspA4), .dsp_b(dspB4), .dsp_opmode(opm4), .dsp_ce(ce4),
    .dsp_p(p4), .busy(busy4)
  );

  dsp_mac_sequencer #(.N_TAPS(1), .OPMODE_DLY(1), .P_LAT(3)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1),
    .dsp_a(dspA1), .dsp_b(dspB1), .dsp_opmode(opm1), .dsp_ce(ce1),
    .dsp_p(p1), .busy(busy1)
  );

  // Slice model: A1/B1 regs, M reg, OPMODE reg, P reg with X/Z post-adder
  logic [17:0] a1r4 = '0, b1r4 = '0, a1r1 = '0, b1r1 = '0;
  logic [35:0] mr4 = '0, mr1 = '0;
  logic [7:0]  opr4 = '0, opr1 = '0;
  logic [47:0] pr4 = '0, pr1 = '0;

  function automatic logic [47:0] slicePost(input logic [7:0] op, input logic [35:0] m,
                                            input logic [47:0] p);
    logic [47:0] x, z;
    x = (op[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
    z = (op[3:2] == 2'b10) ? p : 48'd0;
    return x + z;
  endfunction

  always @(posedge CLK) begin
    if (ce4) begin
      a1r4 <= dspA4; b1r4 <= dspB4; mr4 <= a1r4 * b1r4;
      opr4 <= opm4;  pr4 <= slicePost(opr4, mr4, pr4);
    end
    if (ce1) begin
      a1r1 <= dspA1; b1r1 <= dspB1; mr1 <= a1r1 * b1r1;
      opr1 <= opm1;  pr1 <= slicePost(opr1, mr1, pr1);
    end
  end

  assign p4 = pr4;
  assign p1 = pr1;

  int checks = 0;
  int errors = 0;

  logic [47:0] expQ4[$];
  logic [47:0] expQ1[$];
  logic [47:0] acc[2];
  int          beats[2];
  time         acceptTime[2];

  task automatic checkOutput(input string name, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic readyOf(input int w);
    return (w == 0) ? bus4.s_ready : bus1.s_ready;
  endfunction

  function automatic logic validOf(input int w);
    return (w == 0) ? bus4.m_valid : bus1.m_valid;
  endfunction

  function automatic logic [47:0] dataOf(input int w);
    return (w == 0) ? bus4.m_data : bus1.m_data;
  endfunction

  // Offer one beat, wait for acceptance, and record its product in the scoreboard
  task automatic applyStimulus(input int w, input logic [17:0] a, input logic [17:0] b);
    int n;
    int taps;
    if (w == 0) begin bus4.s_valid = 1'b1; bus4.s_a = a; bus4.s_b = b; end
    else        begin bus1.s_valid = 1'b1; bus1.s_a = a; bus1.s_b = b; end
    n = 0;
    while (!readyOf(w) && n < 100) begin @(negedge CLK); n++; end
    checkOutput("accept_wait", 48'(n < 100), 48'd1);
    acceptTime[w] = $time + 5;
    @(negedge CLK);
    if (w == 0) begin bus4.s_valid = 1'b0; bus4.s_a = '0; bus4.s_b = '0; end
    else        begin bus1.s_valid = 1'b0; bus1.s_a = '0; bus1.s_b = '0; end
    acc[w] = acc[w] + 48'(a) * 48'(b);
    beats[w]++;
    taps = (w == 0) ? 4 : 1;
    if (beats[w] == taps) begin
      if (w == 0) expQ4.push_back(acc[w]); else expQ1.push_back(acc[w]);
      acc[w]   = '0;
      beats[w] = 0;
    end
  endtask

  // Wait for a result, compare against the scoreboard, optionally stall m_ready
  task automatic collectResult(input int w, input int hold);
    int n;
    logic [47:0] exp;
    n = 0;
    while (!validOf(w) && n < 100) begin @(negedge CLK); n++; end
    checkOutput("result_wait", 48'(n < 100), 48'd1);
    if (n >= 100) return;
    checkOutput("latency", 48'(($time - 5 - acceptTime[w]) / 10), 48'(LAT));
    if (((w == 0) ? expQ4.size() : expQ1.size()) == 0) begin
      checkOutput("stale_result", dataOf(w), 48'hFFFF_FFFF_FFFF);
      exp = dataOf(w) ^ 48'd1;
    end else begin
      exp = (w == 0) ? expQ4.pop_front() : expQ1.pop_front();
      checkOutput("m_data", dataOf(w), exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      checkOutput("hold_valid", 48'(validOf(w)), 48'd1);
      checkOutput("hold_data", dataOf(w), exp);
      checkOutput("hold_sready", 48'(readyOf(w)), 48'd0);
    end
    if (w == 0) bus4.m_ready = 1'b1; else bus1.m_ready = 1'b1;
    @(negedge CLK);
    checkOutput("valid_drop", 48'(validOf(w)), 48'd0);
  endtask

  initial begin
    RST = 1'b1;
    bus4.s_valid = 1'b0; bus4.s_a = '0; bus4.s_b = '0; bus4.m_ready = 1'b1;
    bus1.s_valid = 1'b0; bus1.s_a = '0; bus1.s_b = '0; bus1.m_ready = 1'b1;
    acc[0] = '0; acc[1] = '0; beats[0] = 0; beats[1] = 0;
    acceptTime[0] = 0; acceptTime[1] = 0;
    repeat (3) @(negedge CLK);

    $display("[TB] reset values");
    checkOutput("rst_s_ready", 48'(bus4.s_ready), 48'd0);
    checkOutput("rst_dsp_a", 48'(dspA4), 48'd0);
    checkOutput("rst_dsp_b", 48'(dspB4), 48'd0);
    checkOutput("rst_opmode", 48'(opm4), 48'h00);
    checkOutput("rst_ce", 48'(ce4), 48'd0);
    checkOutput("rst_m_valid", 48'(bus4.m_valid), 48'd0);
    checkOutput("rst_m_data", bus4.m_data, 48'd0);
    checkOutput("rst_busy", 48'(busy4), 48'd0);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("post_rst_s_ready", 48'(bus4.s_ready), 48'd1);
    checkOutput("post_rst_ce", 48'(ce4), 48'd1);
    checkOutput("post_rst_opmode", 48'(opm4), 48'h08);

    $display("[TB] back-to-back frame");
    applyStimulus(0, 18'd1, 18'd2);
    applyStimulus(0, 18'd3, 18'd4);
    checkOutput("opm_first", 48'(opm4), 48'h01);
    checkOutput("busy_mid", 48'(busy4), 48'd1);
    applyStimulus(0, 18'd5, 18'd6);
    checkOutput("opm_acc", 48'(opm4), 48'h09);
    applyStimulus(0, 18'd7, 18'd8);
    checkOutput("busy_drain", 48'(busy4), 48'd1);
    collectResult(0, 0);
    checkOutput("busy_idle", 48'(busy4), 48'd0);

    $display("[TB] bubbles mid-frame");
    applyStimulus(0, 18'd1, 18'd2);
    applyStimulus(0, 18'd3, 18'd4);
    @(negedge CLK);
    checkOutput("opm_beat2", 48'(opm4), 48'h09);
    @(negedge CLK);
    checkOutput("opm_bubble1", 48'(opm4), 48'h08);
    applyStimulus(0, 18'd5, 18'd6);
    checkOutput("opm_bubble2", 48'(opm4), 48'h08);
    applyStimulus(0, 18'd7, 18'd8);
    collectResult(0, 0);

    $display("[TB] result backpressure then second frame");
    bus4.m_ready = 1'b0;
    applyStimulus(0, 18'd1, 18'd2);
    applyStimulus(0, 18'd3, 18'd4);
    applyStimulus(0, 18'd5, 18'd6);
    applyStimulus(0, 18'd7, 18'd8);
    collectResult(0, 10);
    for (int i = 0; i < 4; i++) applyStimulus(0, 18'd2, 18'd2);
    collectResult(0, 0);

    $display("[TB] full-scale operands");
    for (int i = 0; i < 4; i++) applyStimulus(0, 18'h3FFFF, 18'h3FFFF);
    checkOutput("max_expected", expQ4[0], 48'd274875809796);
    collectResult(0, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 18'd1, 18'd2);
    applyStimulus(0, 18'd3, 18'd4);
    RST = 1'b1;
    acc[0] = '0;
    beats[0] = 0;
    @(negedge CLK);
    checkOutput("midrst_s_ready", 48'(bus4.s_ready), 48'd0);
    checkOutput("midrst_busy", 48'(busy4), 48'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) applyStimulus(0, 18'd1, 18'd1);
    collectResult(0, 0);
    checkOutput("queue4_empty", 48'(expQ4.size()), 48'd0);

    $display("[TB] single-tap frames");
    applyStimulus(1, 18'd3, 18'd5);
    @(negedge CLK);
    checkOutput("n1_opm_a", 48'(opm1), 48'h01);
    collectResult(1, 0);
    applyStimulus(1, 18'd7, 18'd9);
    @(negedge CLK);
    checkOutput("n1_opm_b", 48'(opm1), 48'h01);
    collectResult(1, 0);
    checkOutput("queue1_empty", 48'(expQ1.size()), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
